bht_update_ctrl: RTL and testbench

Update scheduler for the synchronous branch history table. It accepts resolved-branch outcomes from the execute stage, buffers them in a small FIFO, and drains one update per cycle onto the table's single update port. It forwards the state written by the previous drain so that back-to-back updates to the same branch do not use a stale `update_state_old`. It sits between the EX-stage branch unit and the BHT update inputs.

---
 rtl/bht_update_ctrl.sv | 167 ++++++++++++++++
 tb/tb_bht_update_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bht_update_ctrl.sv
// rtl/bht_update_ctrl.sv - BHT update scheduler: FIFO of resolved branches drained onto the single BHT update port
// Optional feature macro: BHT_UPD_COALESCE_EN (merge a push into a same-pc tail entry)

`ifndef IM_ADDR_BIT
`define IM_ADDR_BIT 32
`endif

module bht_update_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = `IM_ADDR_BIT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [AW-1:0]                 req_pc_4,
    input  logic [AW-1:0]                 req_pc_remote,
    input  logic [1:0]                    req_state_old,
    input  logic                          req_taken,
    input  logic                          drain_en,
    input  logic                          flush,
    output logic                          bht_update_en,
    output logic [AW-1:0]                 bht_update_pc_4,
    output logic [AW-1:0]                 bht_update_pc_remote,
    output logic [1:0]                    bht_update_state_old,
    output logic                          bht_branch_succ,
    output logic [$clog2(DEPTH):0]        occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_DRAIN = 2'b01;
    localparam logic [1:0] ST_HOLD  = 2'b10;

    // 2-bit predictor step: 01 strong-NT, 00 weak-NT, 10 weak-T, 11 strong-T
    function automatic logic [1:0] nxt(input logic [1:0] s, input logic t);
        logic [1:0] r;
        case (s)
            2'b01:   r = t ? 2'b00 : 2'b01;
            2'b00:   r = t ? 2'b10 : 2'b01;
            2'b10:   r = t ? 2'b11 : 2'b00;
            default: r = t ? 2'b11 : 2'b10;
        endcase
        return r;
    endfunction

    logic [AW-1:0] mem_pc_4      [DEPTH];
    logic [AW-1:0] mem_pc_remote [DEPTH];
    logic [1:0]    mem_state     [DEPTH];
    logic          mem_taken     [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [1:0]    st;
    logic          last_v;
    logic [AW-1:0] last_pc_4;
    logic [1:0]    last_state;

    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          coalesce;
    logic          alloc;
    logic [OW-1:0] occ_nxt;
    logic [1:0]    head_state_fwd;

    assign empty = (occupancy == '0);
    assign full  = (occupancy == OW'(DEPTH));

    assign req_ready = !full && !flush;
    assign push      = req_valid && req_ready;

    // st is non-IDLE exactly when the FIFO holds entries, so it stands in for !empty
    assign bht_update_en = (st != ST_IDLE) && drain_en && !flush;
    assign pop           = bht_update_en;

`ifdef BHT_UPD_COALESCE_EN
    logic [PW-1:0] tail_ptr;
    assign tail_ptr = wr_ptr - 1'b1;
    // a single-entry FIFO being popped cannot absorb the push: its tail is leaving
    assign coalesce = push && !empty && (mem_pc_4[tail_ptr] == req_pc_4)
                      && !(pop && (occupancy == OW'(1)));
`else
    assign coalesce = 1'b0;
`endif
    assign alloc = push && !coalesce;

    // head fields, with the previous drain's written state forwarded on a pc match
    assign head_state_fwd       = (last_v && (last_pc_4 == mem_pc_4[rd_ptr]))
                                  ? last_state : mem_state[rd_ptr];
    assign bht_update_pc_4      = mem_pc_4[rd_ptr];
    assign bht_update_pc_remote = mem_pc_remote[rd_ptr];
    assign bht_update_state_old = head_state_fwd;
    assign bht_branch_succ      = mem_taken[rd_ptr];

    // next-cycle occupancy from allocate/pop
    always_comb begin
        occ_nxt = occupancy;
        if (alloc && !pop)
            occ_nxt = occupancy + OW'(1);
        else if (!alloc && pop)
            occ_nxt = occupancy - OW'(1);
    end

    // FIFO storage: allocate at the write pointer or merge into the tail
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc_4[i]      <= '0;
                mem_pc_remote[i] <= '0;
                mem_state[i]     <= '0;
                mem_taken[i]     <= 1'b0;
            end
        end else if (alloc) begin
            mem_pc_4[wr_ptr]      <= req_pc_4;
            mem_pc_remote[wr_ptr] <= req_pc_remote;
            mem_state[wr_ptr]     <= req_state_old;
            mem_taken[wr_ptr]     <= req_taken;
        end
`ifdef BHT_UPD_COALESCE_EN
        else if (coalesce) begin
            mem_state[tail_ptr]     <= nxt(mem_state[tail_ptr], mem_taken[tail_ptr]);
            mem_taken[tail_ptr]     <= req_taken;
            mem_pc_remote[tail_ptr] <= req_pc_remote;
        end
`endif
    end

    // pointers, occupancy, FSM and forwarding history; flush behaves like reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            occupancy  <= '0;
            st         <= ST_IDLE;
            last_v     <= 1'b0;
            last_pc_4  <= '0;
            last_state <= '0;
        end else if (flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
            st        <= ST_IDLE;
            last_v    <= 1'b0;
        end else begin
            occupancy <= occ_nxt;
            if (alloc)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                last_v     <= 1'b1;
                last_pc_4  <= mem_pc_4[rd_ptr];
                last_state <= nxt(head_state_fwd, mem_taken[rd_ptr]);
            end
            if (occ_nxt == '0)
                st <= ST_IDLE;
            else if (drain_en)
                st <= ST_DRAIN;
            else
                st <= ST_HOLD;
        end
    end

endmodule

// File: tb/tb_bht_update_ctrl.sv
// tb/tb_bht_update_ctrl.sv - scoreboard bench for bht_update_ctrl

module tb_bht_update_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc_4;
    logic [31:0] req_pc_remote;
    logic [1:0]  req_state_old;
    logic        req_taken;
    logic        drain_en;
    logic        flush;
    logic        bht_update_en;
    logic [31:0] bht_update_pc_4;
    logic [31:0] bht_update_pc_remote;
    logic [1:0]  bht_update_state_old;
    logic        bht_branch_succ;
    logic [2:0]  occupancy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc_4;
        logic [31:0] pc_remote;
        logic [1:0]  state;
        logic        taken;
    } upd_t;

    upd_t sb[$];

    bht_update_ctrl #(.DEPTH(4), .AW(32)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_pc_4             (req_pc_4),
        .req_pc_remote        (req_pc_remote),
        .req_state_old        (req_state_old),
        .req_taken            (req_taken),
        .drain_en             (drain_en),
        .flush                (flush),
        .bht_update_en        (bht_update_en),
        .bht_update_pc_4      (bht_update_pc_4),
        .bht_update_pc_remote (bht_update_pc_remote),
        .bht_update_state_old (bht_update_state_old),
        .bht_branch_succ      (bht_branch_succ),
        .occupancy            (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // monitor: every BHT write must match the oldest expected update
    always @(negedge clk) begin
        if (rst_n && bht_update_en) begin
            upd_t got;
            upd_t exp_u;
            got = '{bht_update_pc_4, bht_update_pc_remote, bht_update_state_old, bht_branch_succ};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_update: got pc_4=%0h state=%0b with empty scoreboard",
                         got.pc_4, got.state);
            end else begin
                exp_u = sb.pop_front();
                if (got !== exp_u) begin
                    errors++;
                    $display("FAIL update: got pc_4=%0h rem=%0h st=%0b tk=%0b expected pc_4=%0h rem=%0h st=%0b tk=%0b",
                             got.pc_4, got.pc_remote, got.state, got.taken,
                             exp_u.pc_4, exp_u.pc_remote, exp_u.state, exp_u.taken);
                end
            end
        end
    end

    // called just after a posedge; returns just after the accepting posedge
    task automatic push(input logic [31:0] pc4, input logic [31:0] rem, input logic [1:0] so,
                        input logic tk, input bit expect_upd, input logic [1:0] exp_state);
        bit acc = 0;
        req_valid = 1'b1; req_pc_4 = pc4; req_pc_remote = rem;
        req_state_old = so; req_taken = tk;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin acc = 1; break; end
            @(posedge clk); #1;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL push_timeout: req_ready never rose for pc_4=%0h", pc4);
        end else if (expect_upd) begin
            sb.push_back('{pc4, rem, exp_state, tk});
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        bit done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (occupancy == 0 && sb.size() == 0) begin done = 1; break; end
        end
        chk(name, 64'(done), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [5:0] en_mask;
        rst_n = 1'b0; req_valid = 1'b0; req_pc_4 = '0; req_pc_remote = '0;
        req_state_old = '0; req_taken = 1'b0; drain_en = 1'b0; flush = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_update_en", 64'(bht_update_en), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_data", {bht_update_pc_4, bht_update_pc_remote[28:0], bht_update_state_old, bht_branch_succ}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single update
        drain_en = 1'b1;
        push(32'h10, 32'h40, 2'b00, 1'b1, 1, 2'b00);
        @(negedge clk);
        @(negedge clk);
        chk("single_occ_after", 64'(occupancy), 64'd0);
        @(posedge clk); #1;

        // forwarding: second same-pc update sees nxt(00,1)=10
        do_flush();
        push(32'h10, 32'h44, 2'b00, 1'b1, 1, 2'b00);
        push(32'h10, 32'h48, 2'b00, 1'b1, 1, 2'b10);
        wait_empty("fwd_drained");

        // full / hold, then ordered drain
        do_flush();
        drain_en = 1'b0;
        push(32'h100, 32'h1, 2'b01, 1'b1, 1, 2'b01);
        push(32'h104, 32'h2, 2'b00, 1'b0, 1, 2'b00);
        push(32'h108, 32'h3, 2'b10, 1'b1, 1, 2'b10);
        push(32'h10C, 32'h4, 2'b11, 1'b0, 1, 2'b11);
        @(negedge clk);
        chk("full_req_ready", 64'(req_ready), 64'd0);
        chk("full_occupancy", 64'(occupancy), 64'd4);
        chk("full_fsm_hold", 64'(dut.st), 64'd2);
        chk("hold_no_update", 64'(bht_update_en), 64'd0);
        @(posedge clk); #1;
        drain_en = 1'b1;
        en_mask = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            en_mask[i] = bht_update_en;
        end
        chk("drain_consecutive", 64'(en_mask), 64'h0F);
        @(posedge clk); #1;

        // push attempt at full while popping
        drain_en = 1'b0;
        push(32'h200, 32'h5, 2'b00, 1'b1, 1, 2'b00);
        push(32'h204, 32'h6, 2'b00, 1'b1, 1, 2'b00);
        push(32'h208, 32'h7, 2'b00, 1'b1, 1, 2'b00);
        push(32'h20C, 32'h8, 2'b00, 1'b1, 1, 2'b00);
        drain_en = 1'b1; req_valid = 1'b1; req_pc_4 = 32'h300; req_pc_remote = 32'h9;
        req_state_old = 2'b11; req_taken = 1'b1;
        @(negedge clk);
        chk("fullpop_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("fullpop_occupancy", 64'(occupancy), 64'd3);
        wait_empty("fullpop_drained");

        // flush mid-drain: one entry drains, the rest are dropped
        drain_en = 1'b0;
        push(32'h500, 32'hA, 2'b00, 1'b1, 1, 2'b00);
        push(32'h504, 32'hB, 2'b01, 1'b0, 0, 2'b00);
        push(32'h508, 32'hC, 2'b10, 1'b1, 0, 2'b00);
        drain_en = 1'b1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_update_en", 64'(bht_update_en), 64'd0);
        chk("flush_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_occupancy", 64'(occupancy), 64'd0);
        @(posedge clk); #1;
        push(32'h500, 32'hD, 2'b00, 1'b1, 1, 2'b00);
        wait_empty("flush_nofwd_drained");

        // same-pc pushes while holding
        do_flush();
        drain_en = 1'b0;
`ifdef BHT_UPD_COALESCE_EN
        push(32'h20, 32'hE, 2'b01, 1'b1, 0, 2'b00);
        push(32'h20, 32'hF, 2'b01, 1'b1, 1, 2'b00);
        @(negedge clk);
        chk("coalesce_occupancy", 64'(occupancy), 64'd1);
`else
        push(32'h20, 32'hE, 2'b01, 1'b1, 1, 2'b01);
        push(32'h20, 32'hF, 2'b01, 1'b1, 1, 2'b00);
        @(negedge clk);
        chk("samepc_occupancy", 64'(occupancy), 64'd2);
`endif
        @(posedge clk); #1;
        drain_en = 1'b1;
        wait_empty("samepc_drained");

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

endmodule
